// File: rtl/pkt_fifo_commit.sv
// pkt_fifo_commit: store-and-forward frame FIFO with speculative writes.
// Beats of the frame being received sit between commit_ptr and wr_ptr.
// They become readable only when the frame's last beat arrives without
// wr_drop. Bad, overflowing and truncated frames are rewound by moving
// wr_ptr back to commit_ptr, so the read side never sees them.
module pkt_fifo_commit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wrdata,
    input  logic              wr_first,
    input  logic              wr_last,
    input  logic              wr_drop,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rddata,
    output logic              rd_valid,
    output logic              rd_first,
    output logic              rd_last,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   frame_count,
    output logic              bad_drop,
    output logic              ovf_drop,
    output logic              trunc_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef logic [ADDR_W:0] ptr_t;
    typedef enum logic [1:0] {IDLE, WRITE, DISCARD} wr_state_t;

    // Pointer distance that means every entry is occupied.
    localparam ptr_t FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    // Entry layout: {first, last, data}.
    logic [DATA_W+1:0] mem [DEPTH];

    ptr_t      wr_ptr, commit_ptr, rd_ptr;
    ptr_t      wr_ptr_nxt, commit_ptr_nxt, store_addr, used;
    wr_state_t state, state_nxt;
    logic      store, commit_inc, start;
    logic      bad_nxt, ovf_nxt, trunc_nxt;
    logic      rd_fire;
    logic [DATA_W+1:0] rd_entry;

    assign used     = wr_ptr - rd_ptr;
    assign full     = (used == FULL_CNT);
    assign empty    = (rd_ptr == commit_ptr);
    assign rd_fire  = rd_en && !empty;
    assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];

    // A beat that opens a new frame: a first beat from IDLE, or a first
    // (but not last) beat while discarding the tail of an overflowed frame.
    assign start = wr_first && ((state == IDLE) || ((state == DISCARD) && !wr_last));

    // Write-side next state: decide whether the beat is stored, where,
    // and how wr_ptr/commit_ptr move.
    always_comb begin
        // NOTE: every variable gets a default first so that no path through
        // the decision tree leaves it unassigned, which would infer a latch.
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        store          = 1'b0;
        store_addr     = wr_ptr;
        commit_inc     = 1'b0;
        bad_nxt        = 1'b0;
        ovf_nxt        = 1'b0;
        trunc_nxt      = 1'b0;

        if (wr_en) begin
            if ((state == WRITE) && wr_first) begin
                // Abandon the open frame; rewinding always frees at least
                // the one entry it used, so the new first beat always fits.
                trunc_nxt  = 1'b1;
                store      = 1'b1;
                store_addr = commit_ptr;
            end else if ((state == WRITE) || start) begin
                if (full) begin
                    ovf_nxt    = 1'b1;
                    wr_ptr_nxt = commit_ptr;
                    state_nxt  = wr_last ? IDLE : DISCARD;
                end else begin
                    store      = 1'b1;
                    store_addr = wr_ptr;
                end
            end else if ((state == DISCARD) && wr_last) begin
                state_nxt = IDLE;
            end

            if (store) begin
                if (wr_last) begin
                    state_nxt = IDLE;
                    if (wr_drop) begin
                        bad_nxt    = 1'b1;
                        wr_ptr_nxt = commit_ptr;
                    end else begin
                        wr_ptr_nxt     = store_addr + 1'b1;
                        commit_ptr_nxt = store_addr + 1'b1;
                        commit_inc     = 1'b1;
                    end
                end else begin
                    state_nxt  = WRITE;
                    wr_ptr_nxt = store_addr + 1'b1;
                end
            end
        end
    end

    // Write-side registers: FSM state, write/commit pointers, drop pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            bad_drop   <= 1'b0;
            ovf_drop   <= 1'b0;
            trunc_drop <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            bad_drop   <= bad_nxt;
            ovf_drop   <= ovf_nxt;
            trunc_drop <= trunc_nxt;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; entries are only ever read after
        // being written and committed, so their power-up value is irrelevant.
        if (store) begin
            mem[store_addr[ADDR_W-1:0]] <= {wr_first, wr_last, wrdata};
        end
    end

    // Read port: registered beat output, rddata holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            rd_first <= 1'b0;
            rd_last  <= 1'b0;
            rddata   <= '0;
        end else if (rd_fire) begin
            rd_ptr   <= rd_ptr + 1'b1;
            rd_valid <= 1'b1;
            rd_first <= rd_entry[DATA_W+1];
            rd_last  <= rd_entry[DATA_W];
            rddata   <= rd_entry[DATA_W-1:0];
        end else begin
            rd_valid <= 1'b0;
            rd_first <= 1'b0;
            rd_last  <= 1'b0;
        end
    end

    // Committed frame counter: +1 on commit, -1 when a last beat is read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
        end else begin
            case ({commit_inc, rd_fire && rd_entry[DATA_W]})
                2'b10:   frame_count <= frame_count + 1'b1;
                2'b01:   frame_count <= frame_count - 1'b1;
                default: frame_count <= frame_count;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_fifo_commit.sv
// Testbench for pkt_fifo_commit: table-driven vectors, directed multi-cycle
// sequences and randomized traffic against a queue-based reference model.
module tb_pkt_fifo_commit;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en, wr_first, wr_last, wr_drop, rd_en;
    logic [DATA_W-1:0] wrdata;
    logic [DATA_W-1:0] rddata;
    logic              rd_valid, rd_first, rd_last, empty, full;
    logic [ADDR_W:0]   frame_count;
    logic              bad_drop, ovf_drop, trunc_drop;

    pkt_fifo_commit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wrdata(wrdata), .wr_first(wr_first),
        .wr_last(wr_last), .wr_drop(wr_drop), .rd_en(rd_en),
        .rddata(rddata), .rd_valid(rd_valid), .rd_first(rd_first),
        .rd_last(rd_last), .empty(empty), .full(full),
        .frame_count(frame_count), .bad_drop(bad_drop),
        .ovf_drop(ovf_drop), .trunc_drop(trunc_drop)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Committed beats waiting to be read, plus the beats of the frame
    // currently being received. Capacity is the sum of both queues.
    typedef struct packed { logic f; logic l; logic [7:0] d; } beat_t;
    typedef enum {M_IDLE, M_OPEN, M_DISC} m_mode_t;

    beat_t   m_commit[$];
    beat_t   m_spec[$];
    m_mode_t m_mode;
    logic    m_rv, m_rf, m_rl, m_bad, m_ovf, m_trunc;
    logic [7:0] m_rd;

    function automatic int m_frames();
        int n = 0;
        foreach (m_commit[i]) if (m_commit[i].l) n++;
        return n;
    endfunction

    function automatic void model_reset();
        m_commit.delete();
        m_spec.delete();
        m_mode = M_IDLE;
        {m_rv, m_rf, m_rl, m_bad, m_ovf, m_trunc} = '0;
        m_rd = '0;
    endfunction

    function automatic void model_store();
        m_spec.push_back('{f: wr_first, l: wr_last, d: wrdata});
        if (wr_last) begin
            if (wr_drop) m_bad = 1'b1;
            else foreach (m_spec[i]) m_commit.push_back(m_spec[i]);
            m_spec.delete();
            m_mode = M_IDLE;
        end else begin
            m_mode = M_OPEN;
        end
    endfunction

    function automatic void model_clock();
        bit    full_pre;
        bit    fire;
        beat_t b;
        full_pre = (m_commit.size() + m_spec.size()) == DEPTH;
        fire     = rd_en && (m_commit.size() != 0);
        {m_bad, m_ovf, m_trunc} = '0;
        if (fire) begin
            b    = m_commit.pop_front();
            m_rv = 1'b1; m_rf = b.f; m_rl = b.l; m_rd = b.d;
        end else begin
            m_rv = 1'b0; m_rf = 1'b0; m_rl = 1'b0;
        end
        if (wr_en) begin
            if (m_mode == M_OPEN && wr_first) begin
                m_trunc = 1'b1;
                m_spec.delete();
                model_store();
            end else if (m_mode == M_OPEN ||
                         (wr_first && (m_mode == M_IDLE || (m_mode == M_DISC && !wr_last)))) begin
                if (full_pre) begin
                    m_ovf = 1'b1;
                    m_spec.delete();
                    m_mode = wr_last ? M_IDLE : M_DISC;
                end else begin
                    model_store();
                end
            end else if (m_mode == M_DISC && wr_last) begin
                m_mode = M_IDLE;
            end
        end
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_empty"}, empty, m_commit.size() == 0);
        check({tag, "_full"}, full, (m_commit.size() + m_spec.size()) == DEPTH);
        check({tag, "_fc"}, frame_count, m_frames());
        check({tag, "_rv"}, rd_valid, m_rv);
        check({tag, "_rf"}, rd_first, m_rf);
        check({tag, "_rl"}, rd_last, m_rl);
        check({tag, "_rd"}, rddata, m_rd);
        check({tag, "_bad"}, bad_drop, m_bad);
        check({tag, "_ovf"}, ovf_drop, m_ovf);
        check({tag, "_trunc"}, trunc_drop, m_trunc);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic we, input logic wf, input logic wl, input logic wd,
                        input logic [7:0] d, input logic re);
        wr_en = we; wr_first = wf; wr_last = wl; wr_drop = wd; wrdata = d; rd_en = re;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        {wr_en, wr_first, wr_last, wr_drop, rd_en} = '0;
        wrdata = '0;
        rst_n  = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic expect_read(input string name, input logic [7:0] d, input logic f, input logic l);
        step(0, 0, 0, 0, 8'h00, 1);
        check({name, "_rv"}, rd_valid, 1'b1);
        check({name, "_data"}, rddata, d);
        check({name, "_first"}, rd_first, f);
        check({name, "_last"}, rd_last, l);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic we, wf, wl, wd;
        logic [7:0] d;
        logic re;
        logic ee;
        int   efc;
        logic erv, erf, erl;
        logic [7:0] erd;
        logic ebad;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] e;
        int got, max_fc;
        bit drop_seen;
        logic wf, wl;

        // Good 4-beat frame, then read it out with rd_en held.
        tbl[0]  = '{1, 1, 0, 0, 8'h11, 0,  1, 0, 0, 0, 0, 8'h00, 0};
        tbl[1]  = '{1, 0, 0, 0, 8'h22, 0,  1, 0, 0, 0, 0, 8'h00, 0};
        tbl[2]  = '{1, 0, 0, 0, 8'h33, 0,  1, 0, 0, 0, 0, 8'h00, 0};
        tbl[3]  = '{1, 0, 1, 0, 8'h44, 0,  0, 1, 0, 0, 0, 8'h00, 0};
        tbl[4]  = '{0, 0, 0, 0, 8'h00, 1,  0, 1, 1, 1, 0, 8'h11, 0};
        tbl[5]  = '{0, 0, 0, 0, 8'h00, 1,  0, 1, 1, 0, 0, 8'h22, 0};
        tbl[6]  = '{0, 0, 0, 0, 8'h00, 1,  0, 1, 1, 0, 0, 8'h33, 0};
        tbl[7]  = '{0, 0, 0, 0, 8'h00, 1,  1, 0, 1, 0, 1, 8'h44, 0};
        tbl[8]  = '{0, 0, 0, 0, 8'h00, 1,  1, 0, 0, 0, 0, 8'h44, 0};
        // Same frame dropped on its last beat, then a good 2-beat frame.
        tbl[9]  = '{1, 1, 0, 0, 8'h11, 0,  1, 0, 0, 0, 0, 8'h44, 0};
        tbl[10] = '{1, 0, 0, 0, 8'h22, 0,  1, 0, 0, 0, 0, 8'h44, 0};
        tbl[11] = '{1, 0, 0, 0, 8'h33, 0,  1, 0, 0, 0, 0, 8'h44, 0};
        tbl[12] = '{1, 0, 1, 1, 8'h44, 0,  1, 0, 0, 0, 0, 8'h44, 1};
        tbl[13] = '{1, 1, 0, 0, 8'hA1, 0,  1, 0, 0, 0, 0, 8'h44, 0};
        tbl[14] = '{1, 0, 1, 0, 8'hA2, 0,  0, 1, 0, 0, 0, 8'h44, 0};
        tbl[15] = '{0, 0, 0, 0, 8'h00, 1,  0, 1, 1, 1, 0, 8'hA1, 0};
        tbl[16] = '{0, 0, 0, 0, 8'h00, 1,  1, 0, 1, 0, 1, 8'hA2, 0};
        tbl[17] = '{0, 0, 0, 0, 8'h00, 0,  1, 0, 0, 0, 0, 8'hA2, 0};

        // Power-on reset: outputs must take reset values before any clock.
        {wr_en, wr_first, wr_last, wr_drop, rd_en} = '0;
        wrdata = '0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_rv", rd_valid, 1'b0);
        check("rst_rddata", rddata, 8'h00);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_fc", frame_count, 0);
        check("rst_drops", {bad_drop, ovf_drop, trunc_drop}, 3'b000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        // Table-driven vectors.
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].we, tbl[i].wf, tbl[i].wl, tbl[i].wd, tbl[i].d, tbl[i].re);
            check($sformatf("vec%0d_empty", i), empty, tbl[i].ee);
            check($sformatf("vec%0d_fc", i), frame_count, tbl[i].efc);
            check($sformatf("vec%0d_rv", i), rd_valid, tbl[i].erv);
            check($sformatf("vec%0d_rf", i), rd_first, tbl[i].erf);
            check($sformatf("vec%0d_rl", i), rd_last, tbl[i].erl);
            check($sformatf("vec%0d_rd", i), rddata, tbl[i].erd);
            check($sformatf("vec%0d_bad", i), bad_drop, tbl[i].ebad);
        end

        // Overflow: 70-beat frame into 64 entries with no reads.
        do_reset();
        for (int i = 1; i <= 70; i++) begin
            step(1, i == 1, i == 70, 0, 8'(i), 0);
            if (i == 64) begin
                check("ovf_full_at_64", full, 1'b1);
                check("ovf_pulse_64", ovf_drop, 1'b0);
            end
            if (i == 65) check("ovf_pulse_65", ovf_drop, 1'b1);
            if (i == 66) check("ovf_pulse_66", ovf_drop, 1'b0);
        end
        check("ovf_empty", empty, 1'b1);
        check("ovf_full_after", full, 1'b0);
        check("ovf_fc", frame_count, 0);
        step(1, 1, 0, 0, 8'hC1, 0);
        step(1, 0, 0, 0, 8'hC2, 0);
        step(1, 0, 1, 0, 8'hC3, 0);
        check("ovf_next_fc", frame_count, 1);
        expect_read("ovf_r0", 8'hC1, 1, 0);
        expect_read("ovf_r1", 8'hC2, 0, 0);
        expect_read("ovf_r2", 8'hC3, 0, 1);
        check("ovf_drained", empty, 1'b1);

        // Truncation: open 3-beat frame abandoned by a new first beat.
        do_reset();
        step(1, 1, 0, 0, 8'hD1, 0);
        step(1, 0, 0, 0, 8'hD2, 0);
        step(1, 0, 0, 0, 8'hD3, 0);
        check("trunc_before", trunc_drop, 1'b0);
        step(1, 1, 0, 0, 8'hE1, 0);
        check("trunc_pulse", trunc_drop, 1'b1);
        step(1, 0, 1, 0, 8'hE2, 0);
        check("trunc_pulse_end", trunc_drop, 1'b0);
        check("trunc_fc", frame_count, 1);
        expect_read("trunc_r0", 8'hE1, 1, 0);
        expect_read("trunc_r1", 8'hE2, 0, 1);
        step(0, 0, 0, 0, 8'h00, 0);
        check("trunc_empty", empty, 1'b1);
        check("trunc_fc_end", frame_count, 0);

        // Pointer wrap: 20 frames of 7 beats with continuous reads.
        do_reset();
        got = 0; max_fc = 0; drop_seen = 0;
        for (int n = 0; n < 160; n++) begin
            if (n < 140) begin
                exp_q.push_back(8'(n));
                step(1, (n % 7) == 0, (n % 7) == 6, 0, 8'(n), 1);
            end else begin
                step(0, 0, 0, 0, 8'h00, 1);
            end
            if (int'(frame_count) > max_fc) max_fc = int'(frame_count);
            if (bad_drop || ovf_drop || trunc_drop) drop_seen = 1;
            if (rd_valid) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                check($sformatf("wrap_beat%0d", got), rddata, e);
                got++;
            end
        end
        check("wrap_count", got, 140);
        check("wrap_fc_max", max_fc <= 9, 1'b1);
        check("wrap_no_drop", drop_seen, 1'b0);
        check("wrap_empty", empty, 1'b1);

        // Reset mid-frame with a committed frame and a read in flight.
        do_reset();
        step(1, 1, 0, 0, 8'hF1, 0);
        step(1, 0, 1, 0, 8'hF2, 0);
        step(1, 1, 0, 0, 8'hF3, 0);
        step(1, 0, 0, 0, 8'hF4, 1);
        check("mid_pre_rv", rd_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rv", rd_valid, 1'b0);
        check("mid_rst_rf", rd_first, 1'b0);
        check("mid_rst_rddata", rddata, 8'h00);
        check("mid_rst_empty", empty, 1'b1);
        check("mid_rst_fc", frame_count, 0);
        {wr_en, wr_first, wr_last, wr_drop, rd_en} = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        step(0, 0, 0, 0, 8'h00, 1);
        check("mid_post_empty", empty, 1'b1);
        check("mid_post_fc", frame_count, 0);
        check("mid_post_rv", rd_valid, 1'b0);

        // Randomized traffic against the reference model: a slow-read phase
        // that drives the buffer into overflow, then a fast-read phase.
        do_reset();
        for (int phase = 0; phase < 2; phase++) begin
            for (int n = 0; n < 1500; n++) begin
                wf = ($urandom_range(0, 9) == 0);
                wl = ($urandom_range(0, 11) == 0);
                step($urandom_range(0, 3) != 0, wf, wl, $urandom_range(0, 3) == 0,
                     8'($urandom), (phase == 0) ? ($urandom_range(0, 7) == 0)
                                                : ($urandom_range(0, 7) != 0));
                check_model($sformatf("rnd%0d_%0d", phase, n));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
